// File: rtl/im_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into 32-bit words
// and drives a registered word-write port starting at word 0.
module im_loader #(
    parameter int unsigned ADDR_W     = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       end_pc,
    output logic              busy,
    output logic              done,
    output logic              trunc_err,
    output logic              ovf_err
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         asm_q, asm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                trunc_err_q, trunc_err_d;
    logic                ovf_err_q, ovf_err_d;

    logic [1:0]          lane;
    logic [31:0]         word_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            word_count_q <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            trunc_err_q  <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            trunc_err_q  <= trunc_err_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        trunc_err_d  = trunc_err_q;
        ovf_err_d    = ovf_err_q;

        // Big-endian lane for index i is 3-i, which is ~i on two bits.
        lane      = BIG_ENDIAN ? ~idx_q : idx_q;
        word_next = asm_q | ({24'd0, byte_data} << {lane, 3'b000});

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = FILL;
                    word_count_d = '0;
                    idx_d        = '0;
                    asm_d        = '0;
                    trunc_err_d  = 1'b0;
                    ovf_err_d    = 1'b0;
                end
            end
            FILL: begin
                if (byte_valid) begin
                    if (word_count_q == FULL_CNT) begin
                        ovf_err_d = 1'b1;
                        state_d   = DONE;
                    end else if (idx_q == 2'd3 || byte_last) begin
                        // Unfilled lanes are already zero, giving the pad on a short final word.
                        we_d         = 1'b1;
                        waddr_d      = word_count_q[ADDR_W-1:0];
                        wdata_d      = word_next;
                        word_count_d = word_count_q + 1'b1;
                        idx_d        = '0;
                        asm_d        = '0;
                        if (byte_last) begin
                            trunc_err_d = (idx_q != 2'd3);
                            state_d     = DONE;
                        end
                    end else begin
                        asm_d = word_next;
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready = (state_q == FILL);
    assign busy       = (state_q == FILL);
    assign done       = (state_q == DONE);
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign word_count = word_count_q;
    assign trunc_err  = trunc_err_q;
    assign ovf_err    = ovf_err_q;
    assign end_pc     = BASE_ADDR + (32'(word_count_q) << 2);

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader: three instances (big-endian,
// little-endian, 4-word memory) share one byte stream and a byte-level model.
module tb_im_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, byte_valid, byte_last;
    logic [7:0] byte_data;

    logic        br_be, we_be, busy_be, done_be, te_be, oe_be;
    logic [9:0]  wa_be;
    logic [10:0] wc_be;
    logic [31:0] wd_be, pc_be;

    logic        br_le, we_le, busy_le, done_le, te_le, oe_le;
    logic [9:0]  wa_le;
    logic [10:0] wc_le;
    logic [31:0] wd_le, pc_le;

    logic        br_sm, we_sm, busy_sm, done_sm, te_sm, oe_sm;
    logic [1:0]  wa_sm;
    logic [2:0]  wc_sm;
    logic [31:0] wd_sm, pc_sm;

    im_loader u_be (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br_be),
        .we(we_be), .waddr(wa_be), .wdata(wd_be), .word_count(wc_be),
        .end_pc(pc_be), .busy(busy_be), .done(done_be),
        .trunc_err(te_be), .ovf_err(oe_be)
    );

    im_loader #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br_le),
        .we(we_le), .waddr(wa_le), .wdata(wd_le), .word_count(wc_le),
        .end_pc(pc_le), .busy(busy_le), .done(done_le),
        .trunc_err(te_le), .ovf_err(oe_le)
    );

    im_loader #(.ADDR_W(2)) u_sm (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br_sm),
        .we(we_sm), .waddr(wa_sm), .wdata(wd_sm), .word_count(wc_sm),
        .end_pc(pc_sm), .busy(busy_sm), .done(done_sm),
        .trunc_err(te_sm), .ovf_err(oe_sm)
    );

    logic [31:0] o_wa [3];
    logic [31:0] o_wd [3];
    logic [31:0] o_wc [3];
    logic [31:0] o_pc [3];
    logic        o_we [3];
    logic        o_br [3];
    logic        o_busy [3];
    logic        o_done [3];
    logic        o_te [3];
    logic        o_oe [3];

    assign o_wa[0] = 32'(wa_be);  assign o_wa[1] = 32'(wa_le);  assign o_wa[2] = 32'(wa_sm);
    assign o_wd[0] = wd_be;       assign o_wd[1] = wd_le;       assign o_wd[2] = wd_sm;
    assign o_wc[0] = 32'(wc_be);  assign o_wc[1] = 32'(wc_le);  assign o_wc[2] = 32'(wc_sm);
    assign o_pc[0] = pc_be;       assign o_pc[1] = pc_le;       assign o_pc[2] = pc_sm;
    assign o_we[0] = we_be;       assign o_we[1] = we_le;       assign o_we[2] = we_sm;
    assign o_br[0] = br_be;       assign o_br[1] = br_le;       assign o_br[2] = br_sm;
    assign o_busy[0] = busy_be;   assign o_busy[1] = busy_le;   assign o_busy[2] = busy_sm;
    assign o_done[0] = done_be;   assign o_done[1] = done_le;   assign o_done[2] = done_sm;
    assign o_te[0] = te_be;       assign o_te[1] = te_le;       assign o_te[2] = te_sm;
    assign o_oe[0] = oe_be;       assign o_oe[1] = oe_le;       assign o_oe[2] = oe_sm;

    typedef struct {
        int          inst;
        int          t;     // observed: cycle; expected: index of the completing byte
        int          addr;
        logic [31:0] data;
    } wr_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cyc      = 0;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] sb[$];
    bit         sl[$];
    int         pres[$];

    int m_cnt [3];
    int m_done_idx [3];
    bit m_trunc [3];
    bit m_ovf [3];
    bit m_done [3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_we[i] === 1'b1) begin
                wr_t w;
                w.inst = i;
                w.t    = cyc;
                w.addr = int'(o_wa[i]);
                w.data = o_wd[i];
                obs_q.push_back(w);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic string tg(input string a, input string b, input int i);
        return $sformatf("%s.%s[%0d]", a, b, i);
    endfunction

    function automatic int depth_of(input int i);
        return (i == 2) ? 4 : 1024;
    endfunction

    function automatic bit big_of(input int i);
        return (i != 1);
    endfunction

    function automatic logic [7:0] pat(input int k);
        case (k)
            0: return 8'h12;  1: return 8'h34;  2: return 8'h56;  3: return 8'h78;
            4: return 8'h9A;  5: return 8'hBC;  6: return 8'hDE;  default: return 8'hF0;
        endcase
    endfunction

    // Walk the image byte by byte: four bytes (or a last byte) make one word.
    task automatic model_run(input int i);
        int          cnt  = 0;
        int          nb   = 0;
        int          sh;
        bit          fin  = 1'b0;
        logic [31:0] word = '0;
        wr_t         w;
        m_trunc[i]    = 1'b0;
        m_ovf[i]      = 1'b0;
        m_done_idx[i] = sb.size();
        for (int k = 0; k < sb.size() && !fin; k++) begin
            if (cnt == depth_of(i)) begin
                m_ovf[i]      = 1'b1;
                fin           = 1'b1;
                m_done_idx[i] = k;
            end else begin
                sh   = big_of(i) ? (24 - 8 * nb) : (8 * nb);
                word = word | (32'(sb[k]) << sh);
                nb++;
                if (nb == 4 || sl[k]) begin
                    w.inst = i;
                    w.t    = k;
                    w.addr = cnt;
                    w.data = word;
                    exp_q.push_back(w);
                    cnt++;
                    if (sl[k]) begin
                        m_trunc[i]    = (nb < 4);
                        fin           = 1'b1;
                        m_done_idx[i] = k;
                    end
                    word = '0;
                    nb   = 0;
                end
            end
        end
        m_cnt[i]  = cnt;
        m_done[i] = fin;
    endtask

    task automatic check_reset(input string tn);
        for (int i = 0; i < 3; i++) begin
            check(tg(tn, "we", i), 32'(o_we[i]), 32'd0);
            check(tg(tn, "waddr", i), o_wa[i], 32'd0);
            check(tg(tn, "wdata", i), o_wd[i], 32'd0);
            check(tg(tn, "word_count", i), o_wc[i], 32'd0);
            check(tg(tn, "end_pc", i), o_pc[i], BASE);
            check(tg(tn, "busy", i), 32'(o_busy[i]), 32'd0);
            check(tg(tn, "done", i), 32'(o_done[i]), 32'd0);
            check(tg(tn, "trunc_err", i), 32'(o_te[i]), 32'd0);
            check(tg(tn, "ovf_err", i), 32'(o_oe[i]), 32'd0);
            check(tg(tn, "byte_ready", i), 32'(o_br[i]), 32'd0);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic compare_all(input string tn);
        for (int i = 0; i < 3; i++) begin
            wr_t e[$];
            wr_t o[$];
            foreach (exp_q[j]) if (exp_q[j].inst == i) e.push_back(exp_q[j]);
            foreach (obs_q[j]) if (obs_q[j].inst == i) o.push_back(obs_q[j]);
            check(tg(tn, "nwrites", i), o.size(), e.size());
            for (int j = 0; j < e.size() && j < o.size(); j++) begin
                check(tg(tn, "wcycle", i), o[j].t, pres[e[j].t] + 1);
                check(tg(tn, "waddr", i), o[j].addr, e[j].addr);
                check(tg(tn, "wdata", i), o[j].data, e[j].data);
            end
            check(tg(tn, "word_count", i), o_wc[i], m_cnt[i]);
            check(tg(tn, "end_pc", i), o_pc[i], BASE + 32'(4 * m_cnt[i]));
            check(tg(tn, "done", i), 32'(o_done[i]), 32'(m_done[i]));
            check(tg(tn, "busy", i), 32'(o_busy[i]), 32'(!m_done[i]));
            check(tg(tn, "byte_ready", i), 32'(o_br[i]), 32'(!m_done[i]));
            check(tg(tn, "trunc_err", i), 32'(o_te[i]), 32'(m_trunc[i]));
            check(tg(tn, "ovf_err", i), 32'(o_oe[i]), 32'(m_ovf[i]));
            check(tg(tn, "we_idle", i), 32'(o_we[i]), 32'd0);
            if (e.size() > 0) begin
                check(tg(tn, "waddr_hold", i), o_wa[i], e[e.size()-1].addr);
                check(tg(tn, "wdata_hold", i), o_wd[i], e[e.size()-1].data);
            end
        end
    endtask

    // Start pulse carries a junk byte that must not be accepted from IDLE/DONE.
    task automatic run_stream(input string tn, input bit rst_first, input int gap_max, input bit extra);
        int n;
        int g;
        if (rst_first) do_reset();
        n = sb.size();
        exp_q.delete();
        obs_q.delete();
        pres.delete();
        for (int i = 0; i < 3; i++) model_run(i);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        byte_last  = 1'($urandom);
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        for (int k = 0; k < n; k++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                start      = extra && ($urandom_range(0, 2) == 0);
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
            end
            start      = 1'b0;
            byte_valid = 1'b1;
            byte_data  = sb[k];
            byte_last  = sl[k];
            pres.push_back(cyc);
            #1;
            for (int i = 0; i < 3; i++)
                check(tg(tn, "ready_at_byte", i), 32'(o_br[i]), 32'(k <= m_done_idx[i]));
            @(negedge clk);
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        repeat (3) @(negedge clk);
        compare_all(tn);
    endtask

    task automatic set_pattern(input int n, input int last_at);
        sb.delete();
        sl.delete();
        for (int k = 0; k < n; k++) begin
            sb.push_back(pat(k));
            sl.push_back(k == last_at);
        end
    endtask

    task automatic set_random(input int n, input int last_at);
        sb.delete();
        sl.delete();
        for (int k = 0; k < n; k++) begin
            sb.push_back(8'($urandom));
            sl.push_back(k == last_at);
        end
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = '0;
        @(negedge clk);

        set_pattern(8, 7);
        run_stream("base", 1'b1, 0, 1'b0);

        set_pattern(6, 5);
        run_stream("trunc", 1'b1, 0, 1'b0);

        set_random(17, -1);
        run_stream("ovf", 1'b1, 0, 1'b0);

        set_pattern(7, -1);
        run_stream("pre_rst", 1'b1, 0, 1'b0);
        reset = 1'b0;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb.delete();
        sl.delete();
        sb.push_back(8'hAA); sl.push_back(1'b0);
        sb.push_back(8'hBB); sl.push_back(1'b0);
        sb.push_back(8'hCC); sl.push_back(1'b0);
        sb.push_back(8'hDD); sl.push_back(1'b1);
        run_stream("post_rst", 1'b0, 0, 1'b0);

        set_pattern(8, 7);
        run_stream("gaps", 1'b1, 3, 1'b1);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 16));
            set_random(n, ($urandom_range(0, 3) != 0) ? n - 1 : -1);
            run_stream($sformatf("rand%0d", r), 1'b1, 3, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
